// File: rtl/pwm_peripheral.sv
// pwm_peripheral: sixteen chip outputs, each forced low, forced high, or
// driven by one shared 8-bit PWM waveform with a double-buffered duty cycle.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   en_reg_out_7_0/15_8 per-bit output enable (0 = forced low)
//   en_reg_pwm_7_0/15_8 per-bit PWM select (0 = static high when enabled)
//   pwm_duty_cycle      requested duty, sampled only at a period boundary
//   uo_out, uio_out     registered output bits 7:0 and 15:8
//   period_start        one-clk pulse in the first cycle of each PWM period
module pwm_peripheral #(
   parameter int unsigned PRESCALE_DIV = 13
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] en_reg_out_7_0,
   input  logic [7:0] en_reg_out_15_8,
   input  logic [7:0] en_reg_pwm_7_0,
   input  logic [7:0] en_reg_pwm_15_8,
   input  logic [7:0] pwm_duty_cycle,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic       period_start
);

   // A divide-by-one prescaler still needs a 1-bit register to exist.
   localparam int unsigned PW =
      (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE_DIV - 1);

   logic [PW-1:0] pre_cnt_q;
   logic [PW-1:0] pre_cnt_d;
   logic [7:0]    pwm_cnt_q;
   logic [7:0]    pwm_cnt_d;
   logic [7:0]    duty_q;
   logic [7:0]    duty_d;
   logic [15:0]   out_q;
   logic [15:0]   out_d;
   logic          ps_q;
   logic          ps_d;

   logic          tick;
   logic          boundary;
   logic          pwm_level;
   logic [15:0]   en_out;
   logic [15:0]   en_pwm;

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   assign tick     = (pre_cnt_q == PRE_MAX);
   assign boundary = tick && (pwm_cnt_q == 8'hFF);

   // 0xFF is special-cased so a full-scale duty never drops for the
   // last count step of the period.
   assign pwm_level = (duty_q == 8'hFF) ? 1'b1 : (pwm_cnt_q < duty_q);

   always_comb begin
      pre_cnt_d = pre_cnt_q;
      pwm_cnt_d = pwm_cnt_q;
      duty_d    = duty_q;
      ps_d      = 1'b0;

      if (tick) begin
         pre_cnt_d = '0;
         pwm_cnt_d = pwm_cnt_q + 8'd1;
      end else begin
         pre_cnt_d = pre_cnt_q + PW'(1);
      end

      // The shadow duty is loaded on the same edge the counter wraps,
      // so every period runs with a single, stable compare value.
      if (boundary) begin
         duty_d = pwm_duty_cycle;
         ps_d   = 1'b1;
      end
   end

   always_comb begin
      out_d = '0;
      for (int i = 0; i < 16; i++) begin
         if (en_out[i]) begin
            out_d[i] = en_pwm[i] ? pwm_level : 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt_q <= '0;
         pwm_cnt_q <= '0;
         duty_q    <= '0;
         out_q     <= '0;
         ps_q      <= 1'b0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
         pwm_cnt_q <= pwm_cnt_d;
         duty_q    <= duty_d;
         out_q     <= out_d;
         ps_q      <= ps_d;
      end
   end

   assign uo_out       = out_q[7:0];
   assign uio_out      = out_q[15:8];
   assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: directed checks of pwm_peripheral at the default
// prescaler (13) and at a divide-by-one prescaler.
module tb_pwm_peripheral;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] en_out_lo;
   logic [7:0] en_out_hi;
   logic [7:0] en_pwm_lo;
   logic [7:0] en_pwm_hi;
   logic [7:0] duty;
   logic [7:0] uo13;
   logic [7:0] uio13;
   logic       ps13;
   logic [7:0] uo1;
   logic [7:0] uio1;
   logic       ps1;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pwm_peripheral #(.PRESCALE_DIV(13)) dut13 (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_reg_out_7_0  (en_out_lo),
      .en_reg_out_15_8 (en_out_hi),
      .en_reg_pwm_7_0  (en_pwm_lo),
      .en_reg_pwm_15_8 (en_pwm_hi),
      .pwm_duty_cycle  (duty),
      .uo_out          (uo13),
      .uio_out         (uio13),
      .period_start    (ps13)
   );

   pwm_peripheral #(.PRESCALE_DIV(1)) dut1 (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_reg_out_7_0  (en_out_lo),
      .en_reg_out_15_8 (en_out_hi),
      .en_reg_pwm_7_0  (en_pwm_lo),
      .en_reg_pwm_15_8 (en_pwm_hi),
      .pwm_duty_cycle  (duty),
      .uo_out          (uo1),
      .uio_out         (uio1),
      .period_start    (ps1)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ps13(input string tag);
      int i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (ps13 !== 1'b1 && i < 4000);
      check(tag, 32'(ps13), 32'd1);
   endtask

   task automatic wait_ps1(input string tag);
      int i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (ps1 !== 1'b1 && i < 600);
      check(tag, 32'(ps1), 32'd1);
   endtask

   initial begin
      int first13;
      int first1;
      int hi;
      int lo;
      int bad;
      int n_ff;
      int n_f0;
      int pos;

      rst_n     = 1'b0;
      en_out_lo = 8'h00;
      en_out_hi = 8'h00;
      en_pwm_lo = 8'h00;
      en_pwm_hi = 8'h00;
      duty      = 8'h00;
      repeat (3) @(negedge clk);

      // Reset in the middle of a period with outputs active.
      rst_n     = 1'b1;
      en_out_lo = 8'hFF;
      en_out_hi = 8'hFF;
      @(negedge clk);
      check("t1_static_on", 32'(uo13), 32'hFF);
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t1_rst_uo", 32'(uo13), 32'h00);
      check("t1_rst_uio", 32'(uio13), 32'h00);
      check("t1_rst_ps", 32'(ps13), 32'h0);
      repeat (3) @(negedge clk);
      rst_n   = 1'b1;
      first13 = 0;
      first1  = 0;
      for (int i = 1; i <= 4000; i++) begin
         @(negedge clk);
         if (ps1 === 1'b1 && first1 == 0) first1 = i;
         if (ps13 === 1'b1 && first13 == 0) first13 = i;
         if (first13 != 0 && first1 != 0) break;
      end
      check("t1_first_ps13", first13, 3328);
      check("t1_first_ps1", first1, 256);

      // Static-high outputs, one clk after the enable write.
      en_out_lo = 8'h01;
      en_out_hi = 8'h00;
      @(negedge clk);
      check("t2_uo_bit0", 32'(uo13), 32'h01);
      check("t2_uio_off", 32'(uio13), 32'h00);
      en_out_hi = 8'h80;
      @(negedge clk);
      check("t2_uio_bit7", 32'(uio13), 32'h80);

      // 50 % duty on all lower bits.
      duty      = 8'h80;
      en_out_lo = 8'hFF;
      en_pwm_lo = 8'hFF;
      wait_ps13("t3_ps");
      check("t3_uo_at_ps", 32'(uo13), 32'h00);
      @(negedge clk);
      hi = 0;
      while (uo13 === 8'hFF && hi < 4000) begin
         hi++;
         @(negedge clk);
      end
      lo = 0;
      while (uo13 === 8'h00 && lo < 4000) begin
         lo++;
         @(negedge clk);
      end
      check("t3_high_clks", hi, 1664);
      check("t3_low_clks", lo, 1664);

      // Duty extremes over three full periods each.
      duty = 8'h00;
      wait_ps13("t4_ps_00");
      bad = 0;
      for (int i = 0; i < 3 * 3328; i++) begin
         @(negedge clk);
         if (uo13 !== 8'h00) bad++;
      end
      check("t4_duty00_high_clks", bad, 0);
      duty = 8'hFF;
      wait_ps13("t4_ps_ff");
      bad = 0;
      for (int i = 0; i < 3 * 3328; i++) begin
         @(negedge clk);
         if (uo13 !== 8'hFF) bad++;
      end
      check("t4_dutyff_low_clks", bad, 0);
      en_out_lo = 8'h00;
      @(negedge clk);
      check("t4_disabled_pwm", 32'(uo13), 32'h00);
      en_out_lo = 8'hFF;

      // Duty change at pwm_cnt=0x20 waits for the next period.
      duty = 8'h40;
      wait_ps13("t5_ps");
      hi = 0;
      for (int i = 1; i <= 3328; i++) begin
         @(negedge clk);
         if (uo13 === 8'hFF) hi++;
         if (i == 416) duty = 8'hC0;
      end
      check("t5_period_ps", 32'(ps13), 32'h1);
      check("t5_high_old", hi, 832);
      hi = 0;
      for (int i = 1; i <= 3328; i++) begin
         @(negedge clk);
         if (uo13 === 8'hFF) hi++;
      end
      check("t5_high_new", hi, 2496);

      // Divide-by-one: one-clk pulse on the lower nibble only.
      duty      = 8'h01;
      en_out_lo = 8'hFF;
      en_pwm_lo = 8'h0F;
      en_out_hi = 8'h00;
      wait_ps1("t6_ps");
      n_ff = 0;
      n_f0 = 0;
      pos  = 0;
      for (int i = 1; i <= 256; i++) begin
         @(negedge clk);
         if (uo1 === 8'hFF) begin
            n_ff++;
            if (pos == 0) pos = i;
         end
         if (uo1 === 8'hF0) n_f0++;
      end
      check("t6_pulse_clks", n_ff, 1);
      check("t6_static_clks", n_f0, 255);
      check("t6_pulse_pos", pos, 1);
      check("t6_period_ps", 32'(ps1), 32'h1);
      check("t6_uio_off", 32'(uio1), 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
